// File: rtl/not_unit_arbiter.sv
// not_unit_arbiter: round-robin sequencer sharing one registered inverter
// among N_REQ requesters. Optional served-transaction counter is built only
// when NOT_ARB_STATS_EN is defined; otherwise served_cnt is tied to zero.
module not_unit_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 4,
  parameter int LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic                      res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic [$clog2(N_REQ)-1:0]  res_id,
  output logic                      busy,
  output logic [7:0]                served_cnt
);

  localparam int IDW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0]       CNT_INIT = 8'(LATENCY - 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

  logic [1:0]        state;
  logic [IDW-1:0]    rr_ptr;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] cap_word;
  logic [IDW-1:0]    cap_id;

  logic              sel_found;
  logic [IDW-1:0]    sel_id;
  logic [IDW-1:0]    cand;
  logic [DATA_W-1:0] sel_word;

  // Round-robin search: first set request starting at rr_ptr, wrapping mod N_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = rr_ptr + IDW'(i);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign sel_word = req_data[int'(sel_id)*DATA_W +: DATA_W];
  assign busy     = (state != S_IDLE);

  // Sequencer: grant/capture in IDLE, count down in EXEC, present result in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      cap_word  <= '0;
      cap_id    <= '0;
      gnt       <= '0;
      ack       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ena && sel_found) begin
            cap_word <= sel_word;
            cap_id   <= sel_id;
            cnt      <= CNT_INIT;
            gnt      <= ONE << sel_id;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            res_data  <= ~cap_word;
            res_id    <= cap_id;
            res_valid <= 1'b1;
            ack       <= ONE << cap_id;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          res_valid <= 1'b0;
          ack       <= '0;
          gnt       <= '0;
          rr_ptr    <= cap_id + IDW'(1);
          state     <= S_IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          ack       <= '0;
          gnt       <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NOT_ARB_STATS_EN
  logic [7:0] stat_q;

  // Saturating count, bumped as the op enters RESP so it updates with res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (state == S_EXEC && cnt == 8'd0 && stat_q != 8'hFF) begin
      stat_q <= stat_q + 8'd1;
    end
  end

  assign served_cnt = stat_q;
`else
  assign served_cnt = '0;
`endif

endmodule
